// File: rtl/window_scheduler.sv
// Two-requester window scheduler: round-robin grant, then a len+1 cycle RUN window and a one-cycle done pulse.
// Grant appears the cycle after req is sampled in IDLE; requests are only accepted in IDLE, abort cuts GRANT/RUN short.
module window_scheduler #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [1:0]   req,
   input  logic [W-1:0] len0,
   input  logic [W-1:0] len1,
   input  logic         abort,
   output logic [1:0]   gnt,
   output logic         busy,
   output logic [1:0]   done,
   output logic         cycle,
   output logic [W-1:0] ctr
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t       state_q, state_d;
   logic         win_q,   win_d;
   logic         ptr_q,   ptr_d;
   logic [W-1:0] len_q,   len_d;
   logic [W-1:0] ctr_q,   ctr_d;
   logic [1:0]   gnt_q,   gnt_d;
   logic [1:0]   done_q,  done_d;
   logic         pick;

   // A lone requester wins outright; on contention the one not served last wins.
   always_comb begin
      pick = 1'b0;
      case (req)
         2'b01:   pick = 1'b0;
         2'b10:   pick = 1'b1;
         2'b11:   pick = ~ptr_q;
         default: pick = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      ptr_d   = ptr_q;
      len_d   = len_q;
      ctr_d   = ctr_q;
      gnt_d   = gnt_q;
      done_d  = 2'b00;
      case (state_q)
         IDLE: begin
            if (req != 2'b00) begin
               win_d   = pick;
               len_d   = pick ? len1 : len0;
               gnt_d   = pick ? 2'b10 : 2'b01;
               ctr_d   = '0;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (abort) begin
               ptr_d   = win_q;
               gnt_d   = 2'b00;
               ctr_d   = '0;
               state_d = IDLE;
            end else begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (abort) begin
               ptr_d   = win_q;
               gnt_d   = 2'b00;
               ctr_d   = '0;
               state_d = IDLE;
            end else if (ctr_q == len_q) begin
               ctr_d   = '0;
               gnt_d   = 2'b00;
               done_d  = {win_q, ~win_q};
               state_d = DONE;
            end else begin
               ctr_d   = ctr_q + W'(1);
            end
         end
         DONE: begin
            ptr_d   = win_q;
            state_d = IDLE;
         end
         default: begin
            gnt_d   = 2'b00;
            ctr_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         win_q   <= 1'b0;
         ptr_q   <= 1'b1;
         len_q   <= '0;
         ctr_q   <= '0;
         gnt_q   <= 2'b00;
         done_q  <= 2'b00;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         ptr_q   <= ptr_d;
         len_q   <= len_d;
         ctr_q   <= ctr_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
      end
   end

   assign gnt   = gnt_q;
   assign done  = done_q;
   assign ctr   = ctr_q;
   assign busy  = (state_q != IDLE);
   assign cycle = (state_q == RUN);

endmodule

// File: tb/tb_window_scheduler.sv
// Directed bench for window_scheduler: the driver queues cycle-stamped expected outputs,
// a negedge monitor pops and compares them independently of the stimulus.
module tb_window_scheduler;
   localparam int W = 5;

   logic         clk = 1'b0;
   logic         reset;
   logic [1:0]   req;
   logic [W-1:0] len0, len1;
   logic         abort;
   logic [1:0]   gnt, done;
   logic         busy, cycle;
   logic [W-1:0] ctr;

   window_scheduler #(.W(W)) dut (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .len0  (len0),
      .len1  (len1),
      .abort (abort),
      .gnt   (gnt),
      .busy  (busy),
      .done  (done),
      .cycle (cycle),
      .ctr   (ctr)
   );

   always #5 clk = ~clk;

   typedef struct {
      int           at;
      logic [1:0]   g;
      logic [1:0]   d;
      logic         b;
      logic         cy;
      logic [W-1:0] ct;
      string        name;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic push(input int at, input logic [1:0] g, input logic [1:0] d,
                       input logic b, input logic cy, input logic [W-1:0] ct, input string name);
      exp_t e;
      e.at = at; e.g = g; e.d = d; e.b = b; e.cy = cy; e.ct = ct; e.name = name;
      sb.push_back(e);
   endtask

   task automatic push_idle(input int at, input string name);
      push(at, 2'b00, 2'b00, 1'b0, 1'b0, '0, name);
   endtask

   // GRANT at 'start', RUN for len+1 cycles, DONE, then one IDLE cycle.
   task automatic exp_window(input int start, input logic [1:0] g, input int len, input string name);
      push(start, g, 2'b00, 1'b1, 1'b0, '0, {name, "_grant"});
      for (int i = 0; i <= len; i++)
         push(start + 1 + i, g, 2'b00, 1'b1, 1'b1, W'(i), {name, "_run"});
      push(start + len + 2, 2'b00, g, 1'b1, 1'b0, '0, {name, "_done"});
      push_idle(start + len + 3, {name, "_idle"});
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   always @(negedge clk) begin
      checks++;
      if (gnt == 2'b11 || done == 2'b11) begin
         errors++;
         $display("FAIL onehot cyc=%0d got gnt=%b done=%b, need at most one bit each", cyc, gnt, done);
      end
      while (sb.size() > 0 && sb[0].at <= cyc) begin
         mon_e = sb.pop_front();
         checks++;
         if (mon_e.at != cyc ||
             {gnt, done, busy, cycle, ctr} !== {mon_e.g, mon_e.d, mon_e.b, mon_e.cy, mon_e.ct}) begin
            errors++;
            $display("FAIL %s cyc=%0d got gnt=%b done=%b busy=%b cycle=%b ctr=%0d, need (cyc %0d) gnt=%b done=%b busy=%b cycle=%b ctr=%0d",
                     mon_e.name, cyc, gnt, done, busy, cycle, ctr,
                     mon_e.at, mon_e.g, mon_e.d, mon_e.b, mon_e.cy, mon_e.ct);
         end
      end
   end

   initial begin
      reset = 1'b1; req = 2'b11; len0 = '0; len1 = '0; abort = 1'b0;

      // Reset held two cycles with both requesting.
      push_idle(1, "rst_hold1");
      push_idle(2, "rst_hold2");
      wait_cyc(2);

      // Single requester 0, len 3; req drop and len change after latch are ignored.
      reset = 1'b0; req = 2'b01; len0 = 5'd3;
      exp_window(3, 2'b01, 3, "single0");
      push_idle(10, "single0_stay_idle");
      wait_cyc(3);  req  = 2'b00;
      wait_cyc(5);  len0 = 5'd7;

      // Requester 1 with full-range length: counter reaches all-ones and wraps to 0.
      wait_cyc(10);
      req = 2'b10; len1 = 5'd31;
      exp_window(11, 2'b10, 31, "max1");
      wait_cyc(11); req = 2'b00;

      // Contested requests alternate starting with requester 0.
      wait_cyc(45);
      req = 2'b11; len0 = 5'd1; len1 = 5'd2;
      exp_window(46, 2'b01, 1, "rr_a");
      exp_window(51, 2'b10, 2, "rr_b");
      exp_window(57, 2'b01, 1, "rr_c");
      exp_window(62, 2'b10, 2, "rr_d");
      push_idle(68, "rr_end_idle");
      wait_cyc(62); req = 2'b00;

      // Abort at ctr=2: no done, back to IDLE, requester 1 wins next.
      wait_cyc(68);
      req = 2'b11; len0 = 5'd5; len1 = 5'd0;
      push(69, 2'b01, 2'b00, 1'b1, 1'b0, 5'd0, "abort_grant");
      for (int i = 0; i < 3; i++)
         push(70 + i, 2'b01, 2'b00, 1'b1, 1'b1, W'(i), "abort_run");
      push_idle(73, "abort_idle");
      exp_window(74, 2'b10, 0, "post_abort");
      push_idle(78, "post_abort_idle");
      wait_cyc(72); abort = 1'b1;
      wait_cyc(73); abort = 1'b0;
      wait_cyc(74); req = 2'b00;

      // Requester 0 served, then a req held through DONE is not granted until IDLE;
      // reset mid-RUN restores the pointer so requester 0 wins the next contest.
      wait_cyc(78);
      req = 2'b01; len0 = 5'd0;
      exp_window(79, 2'b01, 0, "pre_rst");
      push(83, 2'b10, 2'b00, 1'b1, 1'b0, 5'd0, "midrun_grant");
      for (int i = 0; i < 5; i++)
         push(84 + i, 2'b10, 2'b00, 1'b1, 1'b1, W'(i), "midrun_run");
      push_idle(89, "midrun_reset");
      exp_window(90, 2'b01, 0, "after_rst");
      push_idle(94, "after_rst_idle");
      wait_cyc(79); req = 2'b10; len1 = 5'd9;
      wait_cyc(88); reset = 1'b1; req = 2'b11;
      wait_cyc(89); reset = 1'b0;
      wait_cyc(90); req = 2'b00;

      wait_cyc(96);
      while (sb.size() > 0) begin
         mon_e = sb.pop_front();
         checks++;
         errors++;
         $display("FAIL %s never observed at cyc %0d, still queued", mon_e.name, mon_e.at);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
